// File: rtl/dec_out_formatter.sv
// Decimator output stage: round/scale/saturate the wide filter word, buffer it in a
// first-word-fall-through FIFO and hand it downstream over valid/ready.
module dec_out_formatter #(
    parameter int unsigned IN_W       = 64,
    parameter int unsigned OUT_W      = 24,
    parameter int unsigned SHIFT      = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [IN_W-1:0]               din_i,
    input  logic                          din_vld_i,
    input  logic                          clr_i,
    output logic [OUT_W-1:0]              dout_o,
    output logic                          dout_vld_o,
    input  logic                          dout_rdy_i,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o,
    output logic                          sat_flag_o,
    output logic                          ovf_flag_o,
    output logic [CNT_W-1:0]              sample_cnt_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    // Half-LSB rounding term; collapses to zero when SHIFT is zero.
    localparam logic [IN_W:0] RndTerm = ((IN_W+1)'(1) << SHIFT) >> 1;
    localparam logic signed [IN_W:0] MaxVal = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MinVal = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [AW:0] FullLevel = (AW+1)'(FIFO_DEPTH);

    // Stage 1: round, shift, saturate
    logic signed [IN_W:0] sum_s;
    logic signed [IN_W:0] shr_s;
    logic [OUT_W-1:0]     sat_val;
    logic                 clip;

    always_comb begin
        sum_s   = $signed({din_i[IN_W-1], din_i}) + $signed(RndTerm);
        shr_s   = sum_s >>> SHIFT;
        sat_val = shr_s[OUT_W-1:0];
        clip    = 1'b0;
        if (shr_s > MaxVal) begin
            sat_val = {1'b0, {(OUT_W-1){1'b1}}};
            clip    = 1'b1;
        end else if (shr_s < MinVal) begin
            sat_val = {1'b1, {(OUT_W-1){1'b0}}};
            clip    = 1'b1;
        end
    end

    logic             s1_vld_q;
    logic [OUT_W-1:0] s1_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
        end else begin
            s1_vld_q <= din_vld_i;
            if (din_vld_i) begin
                s1_data_q <= sat_val;
            end
        end
    end

    // Stage 2: FWFT FIFO
    logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [OUT_W-1:0] hold_q, hold_d;
    logic [AW:0]      fill;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;

    always_comb begin
        fill     = wr_ptr_q - rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (fill == FullLevel);
        pop      = ~empty & dout_rdy_i;
        // A full FIFO still accepts when the head leaves on the same edge.
        push     = s1_vld_q & (~full | pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        hold_d   = pop ? mem_q[rd_ptr_q[AW-1:0]] : hold_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= s1_data_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            hold_q   <= hold_d;
        end
    end

    // Status: sticky flags and accepted-sample counter
    logic             sat_q, sat_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sat_d = clr_i ? 1'b0 : sat_q;
        ovf_d = clr_i ? 1'b0 : ovf_q;
        if (din_vld_i && clip) begin
            sat_d = 1'b1;
        end
        if (s1_vld_q && !push) begin
            ovf_d = 1'b1;
        end
        cnt_d = clr_i ? '0 : cnt_q + CNT_W'(push);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            sat_q <= sat_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    // While empty the last popped word stays on the output.
    assign dout_o       = empty ? hold_q : mem_q[rd_ptr_q[AW-1:0]];
    assign dout_vld_o   = ~empty;
    assign fill_o       = fill;
    assign sat_flag_o   = sat_q;
    assign ovf_flag_o   = ovf_q;
    assign sample_cnt_o = cnt_q;

endmodule
